alarm_sched: RTL
================

Name: alarm_sched

Overview:
Timekeeping and alarm scheduler for the alarm clock.
- Consumes the 1 Hz square wave from the clock divider and keeps the HH:MM:SS time of day.
- A button-driven set-mode FSM sets the time and the alarm.
- Decides when the ringer sounds, including snooze re-scheduling and ring timeout.
- Sits between the divider and the display/buzzer drivers.

Parameters:
SNOOZE_MIN, 5, minutes added to current time on snooze (1..59)
RING_SEC, 60, seconds ring stays active if not acknowledged (1..255)
AL_HH_RST, 7, alarm hour after reset (0..23)
AL_MM_RST, 0, alarm minute after reset (0..59)

Ports:
clk  in  1  system clock, same domain as divider
rst  in  1  asynchronous, active-high reset
sec_lvl  in  1  divider 1 Hz square wave; each rising edge = one second
btn_mode  in  1  one-cycle pulse, advance set mode
btn_inc  in  1  one-cycle pulse, increment the field being set
btn_alarm  in  1  one-cycle pulse, toggle alarm enable / stop ring
btn_snooze  in  1  one-cycle pulse, snooze active ring
hh  out  5  hours 0..23
mm  out  6  minutes 0..59
ss  out  6  seconds 0..59
al_hh  out  5  alarm hour
al_mm  out  6  alarm minute
mode  out  3  0 RUN, 1 SET_TH, 2 SET_TM, 3 SET_AH, 4 SET_AM
alarm_en  out  1  alarm armed
ring  out  1  buzzer enable
chime  out  1  hourly chime pulse (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port rst; it is the only reset.
- Reset values: hh=mm=ss=0, al_hh=AL_HH_RST, al_mm=AL_MM_RST, mode=RUN, alarm_en=0, ring=0, chime=0, snooze target invalid, ring counter 0, sec_q=0.
- Tick: register sec_q<=sec_lvl; tick = sec_lvl & ~sec_q.
  - Counters update on the edge where tick=1, so outputs change 1 clk after sec_lvl is sampled high.
  - Exactly one tick per sec_lvl rising edge; a level held high gives no further ticks.
- Time arithmetic:
  - ss 59->0 carries to mm; mm 59->0 carries to hh; hh 23->0.
  - Binary, no BCD.
- Mode FSM: btn_mode steps RUN->SET_TH->SET_TM->SET_AH->SET_AM->RUN.
- SET_TH: btn_inc does hh+1 mod 24.
- SET_TM: btn_inc does mm+1 mod 60 and ss<=0. Ticks are ignored in SET_TH and SET_TM (time frozen).
- SET_AH/SET_AM: btn_inc increments al_hh mod 24 / al_mm mod 60. Time keeps running.
- btn_inc in RUN: ignored.
- btn_alarm (any mode):
  - If ring=1: clears ring and the snooze target; alarm_en is unchanged.
  - Else: toggles alarm_en. Clearing alarm_en also clears ring and the snooze target.
- Match:
  - Evaluated only on a tick edge, against the post-increment time, in any mode except SET_TH/SET_TM.
  - ring<=1 when alarm_en=1, ss==0, and (hh,mm)==(al_hh,al_mm) or (hh,mm)==valid snooze target.
  - A snooze match invalidates the snooze target.
- Ring timeout:
  - Ring counter clears when ring rises and increments on each tick while ring=1.
  - ring<=0 when the counter reaches RING_SEC.
- btn_snooze while ring=1:
  - ring<=0.
  - Snooze target = (hh,mm)+SNOOZE_MIN, minute wrap carrying into hour, hour wrap 23->0.
  - Target valid. A new snooze overwrites the old target.
- btn_snooze while ring=0: ignored.
- Same-cycle priority, highest first: btn_alarm > btn_snooze > match start > timeout. Example: snooze and timeout in the same cycle leaves ring=0 with the target set.
- Button plus tick in the same cycle: both take effect. In SET_TM, btn_inc wins and the tick is dropped.
- btn_mode and btn_inc in the same cycle: btn_inc applies to the old mode, then the mode advances.
- Editing al_hh/al_mm while ringing: ring is unaffected.
- rst mid-ring or mid-set: immediate return to reset values.

Optional Feature:
- Macro: ALARM_SCHED_CHIME_EN.
- Defined: chime pulses high for exactly 1 clk on the tick edge where mm and ss become 0 (hour rollover, including 23->0). Suppressed in SET_TH/SET_TM and while ring=1.
- Undefined: chime is tied to 0 and no chime logic is built. The port list is identical in both builds.

Test Plan:
- rst, then 3 sec_lvl rising edges -> ss=3, each update 1 clk after sec_lvl high; holding sec_lvl high 10000 clk gives no extra tick.
- Preset 23:59:58 via SET_TH/SET_TM, RUN, 2 ticks -> 00:00:00; with ALARM_SCHED_CHIME_EN one 1-clk chime pulse, without it chime stays 0.
- Alarm 07:00, alarm_en=1, time 06:59:59, tick -> ring=1; RING_SEC=60 further ticks -> ring=0 at 07:01:00.
- Ringing at 23:58:00, btn_snooze -> ring=0, target 00:03; ticks to 00:03:00 -> ring=1; btn_alarm -> ring=0, alarm_en still 1.
- In SET_TM apply tick and btn_inc in the same cycle at mm=59 -> mm=0, ss=0, hh unchanged, tick dropped; btn_mode+btn_inc in SET_AM -> al_mm+1 and mode=RUN.
- Assert rst while ring=1 in SET_AH -> next cycle all outputs at reset values, al_hh=7, al_mm=0.

Source files
------------

// File: rtl/alarm_sched.sv
// alarm_sched: HH:MM:SS timekeeper, set-mode FSM and alarm/snooze ringer; hourly chime built only with ALARM_SCHED_CHIME_EN
module alarm_sched #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  parameter int AL_HH_RST  = 7,
  parameter int AL_MM_RST  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_lvl,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  input  logic       btn_snooze,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic [4:0] al_hh,
  output logic [5:0] al_mm,
  output logic [2:0] mode,
  output logic       alarm_en,
  output logic       ring,
  output logic       chime
);
  typedef enum logic [2:0] {RUN, SET_TH, SET_TM, SET_AH, SET_AM} mode_e;
  mode_e mode_q, mode_d;
  logic sec_q, en_q, en_d, ring_q, ring_d, snz_v_q, snz_v_d;
  logic [4:0] hh_q, hh_d, al_hh_q, al_hh_d, snz_hh_q, snz_hh_d;
  logic [5:0] mm_q, mm_d, ss_q, ss_d, al_mm_q, al_mm_d, snz_mm_q, snz_mm_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [6:0] snz_sum, snz_sub;
  logic tick, frozen, run_tick, al_hit, snz_hit, snz_c;
  logic [4:0] hh_inc, al_hh_inc, snz_hh_n;
  logic [5:0] mm_inc, ss_inc, al_mm_inc, snz_mm_n;
  assign tick      = sec_lvl & ~sec_q;
  assign frozen    = (mode_q == SET_TH) || (mode_q == SET_TM);
  assign run_tick  = tick & ~frozen;
  assign hh_inc    = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
  assign mm_inc    = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
  assign ss_inc    = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
  assign al_hh_inc = (al_hh_q == 5'd23) ? 5'd0 : al_hh_q + 5'd1;
  assign al_mm_inc = (al_mm_q == 6'd59) ? 6'd0 : al_mm_q + 6'd1;
  assign cnt_inc   = cnt_q + 8'd1;
  // snooze target is computed from the time shown when the button is pressed
  assign snz_sum   = {1'b0, mm_q} + 7'(SNOOZE_MIN);
  assign snz_sub   = snz_sum - 7'd60;
  assign snz_c     = snz_sum >= 7'd60;
  assign snz_mm_n  = snz_c ? snz_sub[5:0] : snz_sum[5:0];
  assign snz_hh_n  = snz_c ? hh_inc : hh_q;
  assign al_hit    = (hh_d == al_hh_q) && (mm_d == al_mm_q);
  assign snz_hit   = snz_v_q && (hh_d == snz_hh_q) && (mm_d == snz_mm_q);
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    en_d = en_q;
    ring_d = ring_q;
    snz_v_d = snz_v_q;
    snz_hh_d = snz_hh_q;
    snz_mm_d = snz_mm_q;
    if (run_tick) begin
      ss_d = ss_inc;
      mm_d = (ss_q == 6'd59) ? mm_inc : mm_q;
      hh_d = (ss_q == 6'd59 && mm_q == 6'd59) ? hh_inc : hh_q;
    end
    if (btn_inc && mode_q == SET_TH) hh_d = hh_inc;
    if (btn_inc && mode_q == SET_TM) begin
      mm_d = mm_inc;
      ss_d = 6'd0;
    end
    if (btn_inc && mode_q == SET_AH) al_hh_d = al_hh_inc;
    if (btn_inc && mode_q == SET_AM) al_mm_d = al_mm_inc;
    mode_d = btn_mode ? ((mode_q == SET_AM) ? RUN : mode_e'(mode_q + 3'd1)) : mode_q;
    // lowest priority first so later assignments override: timeout, match, snooze, alarm button
    if (tick && ring_q && cnt_inc >= 8'(RING_SEC)) ring_d = 1'b0;
    if (run_tick && en_q && ss_d == 6'd0 && (al_hit || snz_hit)) begin
      ring_d = 1'b1;
      snz_v_d = snz_hit ? 1'b0 : snz_v_q;
    end
    if (btn_snooze && ring_q) begin
      ring_d = 1'b0;
      snz_v_d = 1'b1;
      snz_hh_d = snz_hh_n;
      snz_mm_d = snz_mm_n;
    end
    if (btn_alarm) begin
      en_d = ring_q ? en_q : ~en_q;
      ring_d = (ring_q || en_q) ? 1'b0 : ring_d;
      snz_v_d = (ring_q || en_q) ? 1'b0 : snz_v_d;
    end
    cnt_d = (ring_d && !ring_q) ? 8'd0 : (tick && ring_q) ? cnt_inc : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= 1'b0;
      hh_q <= 5'd0;
      mm_q <= 6'd0;
      ss_q <= 6'd0;
      al_hh_q <= 5'(AL_HH_RST);
      al_mm_q <= 6'(AL_MM_RST);
      mode_q <= RUN;
      en_q <= 1'b0;
      ring_q <= 1'b0;
      cnt_q <= 8'd0;
      snz_v_q <= 1'b0;
      snz_hh_q <= 5'd0;
      snz_mm_q <= 6'd0;
    end else begin
      sec_q <= sec_lvl;
      hh_q <= hh_d;
      mm_q <= mm_d;
      ss_q <= ss_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      mode_q <= mode_d;
      en_q <= en_d;
      ring_q <= ring_d;
      cnt_q <= cnt_d;
      snz_v_q <= snz_v_d;
      snz_hh_q <= snz_hh_d;
      snz_mm_q <= snz_mm_d;
    end
  end
`ifdef ALARM_SCHED_CHIME_EN
  logic chime_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chime_q <= 1'b0;
    else chime_q <= run_tick && !ring_q && ss_d == 6'd0 && mm_d == 6'd0;
  end
  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif
  assign hh = hh_q;
  assign mm = mm_q;
  assign ss = ss_q;
  assign al_hh = al_hh_q;
  assign al_mm = al_mm_q;
  assign mode = mode_q;
  assign alarm_en = en_q;
  assign ring = ring_q;
endmodule
